uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Upstream stage of the core: receives a program image byte-stream from the UART receiver and writes it word-by-word into instruction/data RAM starting at address 0.
- On successful load it pulses the core's `ena` input, releasing the core from HALT to fetch from address 0.
- While loading it owns the RAM port. External muxing selects loader vs core signals using `bus_own`.

Parameters:
- ADDR_W, 13: RAM word-address width; matches core `ram_addres`.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 100000: max idle clocks between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
- ram_addres  output  ADDR_W  RAM write address
- ram_data  output  32  RAM write data
- ram_we  output  1  RAM write enable, one cycle per word
- bus_own  output  1  high while loader drives RAM (frame in progress)
- core_ena  output  1  one-cycle pulse to core `ena` after good load
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky error flag; cleared on next accepted SYNC_BYTE

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0; state IDLE; counters 0.
  - Reset mid-frame abandons the frame; words already written stay in RAM.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each, little-endian (first byte -> bits [7:0]).
  - LEN is a 16-bit word count.
- State machine:
  - IDLE: wait rx_valid with rx_data==SYNC_BYTE -> LEN_LO, clear err, set bus_own. Other bytes are ignored.
  - LEN_LO: on rx_valid latch low byte -> LEN_HI.
  - LEN_HI: on rx_valid latch high byte.
    - If LEN==0 -> DONE.
    - If LEN > 2^ADDR_W -> ERROR.
    - Else -> DATA with byte index 0 and word address 0.
  - DATA: each rx_valid shifts the byte into the assembly register at lane byte_idx; byte_idx increments mod 4. On the 4th byte -> WRITE.
  - WRITE (1 cycle):
    - ram_we=1, ram_data=assembled word, ram_addres=word address.
    - Word address +1, words_left -1.
    - If words_left becomes 0 -> DONE (or CHECK when feature enabled), else -> DATA.
    - An rx_valid arriving in WRITE is captured as byte 0 of the next word; no byte is lost.
  - DONE (1 cycle): core_ena=1, bus_own drops to 0 in the same cycle -> IDLE.
  - ERROR (1 cycle): err<=1, bus_own<=0, core_ena stays 0 -> IDLE.
- Timeout:
  - Cycle counter cleared on every rx_valid; counts only in LEN_LO, LEN_HI, DATA.
  - Reaching TIMEOUT_CYC -> ERROR.
  - Counter saturates; no wrap.
- Latency:
  - ram_we asserts exactly 1 cycle after the rx_valid carrying the 4th byte of a word.
  - core_ena asserts 1 cycle after the last WRITE.
- Word address: ADDR_W bits; LEN == 2^ADDR_W fills RAM exactly. The address wraps to 0 internally but is never written again.
- busy: high LEN_LO..ERROR inclusive.
- bus_own: high from SYNC acceptance until DONE/ERROR.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHECK waits one further byte and compares it to the running XOR of all data bytes.
  - The running XOR is reset at SYNC and excludes the LEN bytes.
  - Match -> DONE; mismatch -> ERROR (RAM already written, core not enabled).
  - Timeout also applies in CHECK.
  - LEN==0 still goes through CHECK with expected value 8'h00.
- Not defined: no CHECK state, no XOR logic; last WRITE goes directly to DONE.

Test Plan:
- Basic load:
  - Stimulus: A5, 02, 00, 11 22 33 44, AA BB CC DD.
  - Required: ram_we at addr 0 data 32'h44332211, then at addr 1 data 32'hDDCCBBAA. core_ena is a single-cycle pulse 1 clk after 2nd write; err=0.
- Zero length: A5, 00, 00 -> no ram_we; core_ena pulses 1 clk after LEN_HI byte (with BOOT_CHECKSUM_EN: after the trailing 00 byte).
- Timeout:
  - Stimulus: A5, 01, 00, 11 22, then silence for TIMEOUT_CYC clocks.
  - Required: err=1, bus_own=0, no ram_we, no core_ena.
  - Follow-up: a new A5 clears err.
- Oversize: A5, 01, 21 (LEN=0x2101 > 8192) -> ERROR, err=1, no writes.
- Back-to-back: the next word's first byte rx_valid coincides with the WRITE cycle -> no byte lost; 2nd word correct.
- Reset mid-frame and checksum:
  - rst_n low during DATA -> outputs 0 immediately, state IDLE.
  - BOOT_CHECKSUM_EN: frame A5 01 00 01 02 04 08 + 0F -> core_ena pulse; same frame with checksum 0E -> err=1, no core_ena.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Loads a SYNC/LEN-framed byte stream from the UART into RAM word by word, then pulses core_ena.
// Latency: ram_we 1 clk after a word's 4th byte, core_ena 1 clk after the last write. No backpressure: every rx_valid is consumed.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte that must match before the core is released.
module uart_boot_loader #(
  parameter int          ADDR_W      = 13,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_addres,
  output logic [31:0]       ram_data,
  output logic              ram_we,
  output logic              bus_own,
  output logic              core_ena,
  output logic              busy,
  output logic              err
);

  localparam int              TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
  localparam logic [31:0]     MAX_LEN = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef BOOT_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       len_w;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_acc;
`endif

  assign len_w = {rx_data, len_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      words_left <= '0;
      word_addr  <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      tmo_cnt    <= '0;
      ram_addres <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      bus_own    <= 1'b0;
      core_ena   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_acc    <= '0;
`endif
    end else begin
      ram_we   <= 1'b0;
      core_ena <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state   <= S_LEN_LO;
            err     <= 1'b0;
            bus_own <= 1'b1;
            busy    <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            xor_acc <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            len_lo  <= rx_data;
            tmo_cnt <= '0;
            state   <= S_LEN_HI;
          end else if (tmo_cnt >= TMO_MAX) begin
            state   <= S_ERROR;
            err     <= 1'b1;
            bus_own <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            tmo_cnt    <= '0;
            words_left <= len_w;
            word_addr  <= '0;
            byte_idx   <= '0;
            if (len_w == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state    <= S_CHECK;
`else
              state    <= S_DONE;
              core_ena <= 1'b1;
              bus_own  <= 1'b0;
`endif
            end else if ({16'd0, len_w} > MAX_LEN) begin
              state   <= S_ERROR;
              err     <= 1'b1;
              bus_own <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else if (tmo_cnt >= TMO_MAX) begin
            state   <= S_ERROR;
            err     <= 1'b1;
            bus_own <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            // bytes arrive lane 0 first, so shifting right lands each in its lane
            tmo_cnt  <= '0;
            asm_q    <= {rx_data, asm_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            xor_acc  <= xor_acc ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              ram_we     <= 1'b1;
              ram_data   <= {rx_data, asm_q};
              ram_addres <= word_addr;
            end
          end else if (tmo_cnt >= TMO_MAX) begin
            state   <= S_ERROR;
            err     <= 1'b1;
            bus_own <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WRITE: begin
          word_addr  <= word_addr + ADDR_W'(1);
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
            // a byte landing in this cycle is already the checksum
            if (rx_valid) begin
              bus_own <= 1'b0;
              if (rx_data == xor_acc) begin
                state    <= S_DONE;
                core_ena <= 1'b1;
              end else begin
                state <= S_ERROR;
                err   <= 1'b1;
              end
            end else begin
              state <= S_CHECK;
            end
`else
            state    <= S_DONE;
            core_ena <= 1'b1;
            bus_own  <= 1'b0;
`endif
          end else begin
            state <= S_DATA;
            if (rx_valid) begin
              tmo_cnt  <= '0;
              asm_q    <= {rx_data, asm_q[23:8]};
              byte_idx <= 2'd1;
`ifdef BOOT_CHECKSUM_EN
              xor_acc  <= xor_acc ^ rx_data;
`endif
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid) begin
            bus_own <= 1'b0;
            if (rx_data == xor_acc) begin
              state    <= S_DONE;
              core_ena <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end else if (tmo_cnt >= TMO_MAX) begin
            state   <= S_ERROR;
            err     <= 1'b1;
            bus_own <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
`endif
        S_DONE, S_ERROR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          bus_own <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: RAM writes and core_ena pulses are scored against a queue of expected events.
module tb_uart_boot_loader;

  localparam int         ADDR_W = 13;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         TMO    = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] ram_addres;
  logic [31:0]       ram_data;
  logic              ram_we;
  logic              bus_own;
  logic              core_ena;
  logic              busy;
  logic              err;

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_addres(ram_addres), .ram_data(ram_data), .ram_we(ram_we),
    .bus_own(bus_own), .core_ena(core_ena), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       we_q[$];
  int         ena_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last = 0;
  logic [7:0] cs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; scores any write or enable pulse seen on this cycle.
  task automatic tick();
    exp_t e;
    int   ec;
    @(negedge clk);
    cyc++;
    if (ram_we) begin
      if (we_q.size() == 0) chk("ram_we_spurious", 32'(ram_we), 32'd0);
      else begin
        e = we_q.pop_front();
        chk("wr_addr", 32'(ram_addres), e.addr);
        chk("wr_data", ram_data, e.data);
        chk("wr_cycle", 32'(cyc), e.cyc);
      end
    end
    if (core_ena) begin
      if (ena_q.size() == 0) chk("core_ena_spurious", 32'(core_ena), 32'd0);
      else begin
        ec = ena_q.pop_front();
        chk("ena_cycle", 32'(cyc), ec);
      end
    end
  endtask

  task automatic put(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic start(input logic [15:0] len);
    cs = 8'h00;
    put(SYNC);
    put(len[7:0]);
    put(len[15:8]);
    last = cyc;
  endtask

  task automatic word(input int addr, input logic [31:0] data, input int gap);
    logic [7:0] b;
    exp_t       e;
    for (int i = 0; i < 4; i++) begin
      b = data[8*i +: 8];
      put(b);
      cs = cs ^ b;
      if (i == 3) begin
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc + 1;
        we_q.push_back(e);
        last = cyc + 1;
      end
      quiet(gap);
    end
  endtask

  task automatic finish_ok();
`ifdef BOOT_CHECKSUM_EN
    put(cs);
    ena_q.push_back(cyc + 1);
`else
    ena_q.push_back(last + 1);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(ram_addres), 32'd0);
    chk({tag, "_data"},  ram_data,        32'd0);
    chk({tag, "_we"},    32'(ram_we),     32'd0);
    chk({tag, "_own"},   32'(bus_own),    32'd0);
    chk({tag, "_ena"},   32'(core_ena),   32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    quiet(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    quiet(2);

    // basic two-word load with idle gaps between bytes
    start(16'd2);
    quiet(1);
    chk("basic_own", 32'(bus_own), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    word(0, 32'h44332211, 1);
    word(1, 32'hDDCCBBAA, 1);
    finish_ok();
    quiet(4);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_own_end", 32'(bus_own), 32'd0);
    chk("basic_busy_end", 32'(busy), 32'd0);

    // zero length releases the core without writing
    start(16'd0);
    finish_ok();
    quiet(4);
    chk("zero_err", 32'(err), 32'd0);

    // back-to-back bytes: next word's first byte lands in the WRITE cycle
    start(16'd3);
    word(0, 32'h04030201, 0);
    word(1, 32'h08070605, 0);
    word(2, 32'h0C0B0A09, 0);
    finish_ok();
    quiet(4);
    chk("b2b_err", 32'(err), 32'd0);

    // timeout mid-word
    start(16'd1);
    put(8'h11);
    put(8'h22);
    quiet(TMO + 8);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_own", 32'(bus_own), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    put(SYNC);
    quiet(1);
    chk("sync_clears_err", 32'(err), 32'd0);
    chk("sync_sets_own", 32'(bus_own), 32'd1);

    // oversize LEN = 0x2101 continuing the frame just opened
    put(8'h01);
    put(8'h21);
    quiet(3);
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_own", 32'(bus_own), 32'd0);

    // LEN one above capacity is rejected, exactly capacity is accepted
    start(16'h2001);
    quiet(3);
    chk("len_2001_err", 32'(err), 32'd1);
    start(16'h2000);
    quiet(2);
    chk("len_2000_err", 32'(err), 32'd0);
    chk("len_2000_busy", 32'(busy), 32'd1);
    chk("len_2000_own", 32'(bus_own), 32'd1);

    // asynchronous reset in the middle of DATA
    put(8'h01);
    put(8'h02);
    quiet(1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    quiet(1);
    rst_n = 1'b1;
    quiet(1);

    // loader recovers and writes from address 0 again
    start(16'd1);
    word(0, 32'hCAFEF00D, 1);
    finish_ok();
    quiet(4);
    chk("recover_err", 32'(err), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    start(16'd1);
    word(0, 32'h08040201, 1);
    put(8'h0F);
    ena_q.push_back(cyc + 1);
    quiet(4);
    chk("cs_good_err", 32'(err), 32'd0);

    start(16'd1);
    word(0, 32'h08040201, 1);
    put(8'h0E);
    quiet(4);
    chk("cs_bad_err", 32'(err), 32'd1);
    chk("cs_bad_own", 32'(bus_own), 32'd0);
`endif

    chk("writes_drained", 32'(we_q.size()), 32'd0);
    chk("enables_drained", 32'(ena_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
